const_div_reconstruct: RTL and testbench

//  Inverse of the constant divide-by-D datapath: rebuilds dividend X = Q*D + R from a quotient/remainder pair.

---
 rtl/const_div_pkg.sv | 24 ++
 rtl/const_div_digit_mac.sv | 28 ++
 rtl/const_div_reconstruct.sv | 123 ++++++++++++
 tb/tb_const_div_reconstruct.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/const_div_pkg.sv
// Shared parameters and types for the constant-divisor reconstruction datapath.
// Optional range checking in the top is enabled by defining DIVREC_RANGE_CHECK_EN.
package const_div_pkg;

    localparam int N    = 16;
    localparam int D    = 23;
    localparam int K    = 4;
    localparam int QW   = N - ($clog2(D + 1) - 1);
    localparam int RW   = $clog2(D);
    localparam int CW   = RW + 1;
    localparam int PW   = K + RW + 1;
    localparam int SW   = QW + CW;
    localparam int NDIG = QW / K;
    localparam int CNTW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef logic [CNTW-1:0] dcnt_t;

endpackage

// File: rtl/const_div_digit_mac.sv
// One reconstruction step: digit*D + carry, split into the low K result bits and the next carry.
// D is a constant, so the product is a fixed shift-add network rather than a multiplier.
module const_div_digit_mac
    import const_div_pkg::*;
(
    input  logic [K-1:0]  i_digit,
    input  logic [CW-1:0] i_carry,
    output logic [K-1:0]  o_digit,
    output logic [CW-1:0] o_carry
);

    localparam logic [PW-1:0] DV = PW'(D);

    logic [PW-1:0] w_p;

    always_comb begin
        w_p = PW'(i_carry);
        for (int b = 0; b < PW; b++) begin
            if (DV[b]) begin
                w_p = w_p + (PW'(i_digit) << b);
            end
        end
    end

    assign o_digit = w_p[K-1:0];
    assign o_carry = w_p[PW-1:K];

endmodule

// File: rtl/const_div_reconstruct.sv
// Rebuilds X = Q*D + R digit-serially, LSB digit first, one K-bit quotient digit per cycle.
// Define DIVREC_RANGE_CHECK_EN to flag r_in >= D or results wider than N bits on range_err.
module const_div_reconstruct
    import const_div_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [QW-1:0] q_in,
    input  logic [RW-1:0] r_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  x_out,
    output logic          range_err
);

    state_t        r_state;
    state_t        w_next_state;
    logic [QW-1:0] r_q;
    logic [QW-1:0] r_digits;
    logic [CW-1:0] r_carry;
    dcnt_t         r_cnt;
    logic [N-1:0]  r_x_out;
    logic [K-1:0]  w_digit;
    logic [CW-1:0] w_carry;
    logic [SW-1:0] w_sum;
    logic [N-1:0]  w_x;
    logic          w_last;

    const_div_digit_mac u_mac (
        .i_digit (r_q[K-1:0]),
        .i_carry (r_carry),
        .o_digit (w_digit),
        .o_carry (w_carry)
    );

    assign w_last = (r_cnt == dcnt_t'(NDIG - 1));
    // Full-width result as it stands after the final digit; bits above N are dropped from x_out.
    assign w_sum  = {w_carry, w_digit, r_digits[QW-1:K]};
    assign w_x    = N'(w_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next_state = S_RUN;
            S_RUN:   if (w_last)    w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default:                w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q      <= '0;
            r_digits <= '0;
            r_carry  <= '0;
            r_cnt    <= '0;
            r_x_out  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_q     <= q_in;
                        r_carry <= {1'b0, r_in};
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_q      <= r_q >> K;
                    r_carry  <= w_carry;
                    r_digits <= {w_digit, r_digits[QW-1:K]};
                    r_cnt    <= r_cnt + dcnt_t'(1);
                    if (w_last) begin
                        r_x_out <= w_x;
                    end
                end
                default: ;
            endcase
        end
    end

    assign x_out = r_x_out;

`ifdef DIVREC_RANGE_CHECK_EN
    logic r_r_bad;
    logic r_range_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r_bad     <= 1'b0;
            r_range_err <= 1'b0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_r_bad <= ({1'b0, r_in} >= CW'(D));
        end else if (r_state == S_RUN && w_last) begin
            r_range_err <= r_r_bad | (|w_sum[SW-1:N]);
        end
    end

    assign range_err = r_range_err;
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_const_div_reconstruct.sv
// Self-checking bench for const_div_reconstruct: directed vector table, handshake corner cases,
// and a randomized sweep against X = Q*23 + R (truncated to 16 bits).
module tb_const_div_reconstruct;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] q_in;
    logic [4:0]  r_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] x_out;
    logic        range_err;

    int n_chk = 0;
    int n_err = 0;

`ifdef DIVREC_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    const_div_reconstruct dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q_in      (q_in),
        .r_in      (r_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int q;
        int r;
        int exp_x;
        bit exp_err;
    } vec_t;

    function automatic int ref_x(input int q, input int r);
        return (q * 23 + r) % 65536;
    endfunction

    function automatic bit ref_err(input int q, input int r);
        return RC && ((r >= 23) || (q * 23 + r > 65535));
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // lat counts rising edges from the accepting edge up to and including the edge raising out_valid.
    // hold: 0 = accept result at once, >0 = keep out_ready low that many cycles, <0 = random out_ready.
    task automatic run_pair(input int q, input int r, input int hold,
                            output int lat, output logic [15:0] x, output logic e,
                            output bit stable_ok, output bit done_ok);
        int n;
        stable_ok = 1'b1;
        done_ok   = 1'b1;
        lat       = 0;
        x         = '0;
        e         = 1'b0;
        q_in      = 12'(q);
        r_in      = 5'(r);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            done_ok  = 1'b0;
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        n = 0;
        while (!out_valid && n < 30) begin
            @(negedge clk);
            lat++;
            n++;
        end
        if (!out_valid) begin
            done_ok = 1'b0;
            return;
        end
        x = x_out;
        e = range_err;
        n = 0;
        if (hold == 0)     out_ready = 1'b1;
        else if (hold > 0) out_ready = 1'b0;
        else               out_ready = ($urandom_range(0, 2) != 0);
        while (!out_ready) begin
            @(negedge clk);
            n++;
            if (x_out !== x || range_err !== e || out_valid !== 1'b1 || in_ready !== 1'b0)
                stable_ok = 1'b0;
            if (hold >= 0) out_ready = (n >= hold);
            else           out_ready = ($urandom_range(0, 2) != 0) || (n >= 300);
        end
        @(negedge clk);
        out_ready = 1'b0;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) done_ok = 1'b0;
    endtask

    initial begin
        vec_t        vecs[8];
        int          lat;
        logic [15:0] x;
        logic        e;
        bit          st_ok;
        bit          dn_ok;
        bit          seen;
        int          n;
        int          q;
        int          r;

        vecs[0] = '{0,    0,  0,     1'b0};
        vecs[1] = '{2849, 8,  65535, 1'b0};
        vecs[2] = '{1,    22, 45,    1'b0};
        vecs[3] = '{100,  5,  2305,  1'b0};
        vecs[4] = '{2850, 0,  14,    RC};
        vecs[5] = '{0,    23, 23,    RC};
        vecs[6] = '{4095, 31, 28680, RC};
        vecs[7] = '{1,    0,  23,    1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        q_in      = '0;
        r_in      = '0;
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_x_out", x_out, 0);
        chk("reset_range_err", range_err, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            run_pair(vecs[i].q, vecs[i].r, 0, lat, x, e, st_ok, dn_ok);
            chk($sformatf("vec%0d_x", i), x, vecs[i].exp_x);
            chk($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
            chk($sformatf("vec%0d_latency", i), lat, 4);
            chk($sformatf("vec%0d_handshake", i), dn_ok, 1);
        end

        // Consumer stalls 10 cycles in DONE; result must hold, then transfer exactly once.
        run_pair(1234, 17, 10, lat, x, e, st_ok, dn_ok);
        chk("stall_x", x, 1234 * 23 + 17);
        chk("stall_stable", st_ok, 1);
        chk("stall_single_transfer", dn_ok, 1);

        // Reset during the second RUN cycle aborts the operation.
        q_in = 12'd50; r_in = 5'd3; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 30) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_in_ready_async", in_ready, 1);
        chk("abort_out_valid_async", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_out_valid", seen, 0);
        chk("abort_in_ready", in_ready, 1);
        run_pair(100, 5, 0, lat, x, e, st_ok, dn_ok);
        chk("after_abort_x", x, 2305);
        chk("after_abort_handshake", dn_ok, 1);

        // New pair offered while busy and during completion: only the completion is taken first.
        q_in = 12'd100; r_in = 5'd5; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 30) begin @(negedge clk); n++; end
        @(negedge clk);
        q_in = 12'd1; r_in = 5'd22; out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 30) begin @(negedge clk); n++; end
        chk("overlap_first_x", x_out, 2305);
        @(negedge clk);
        chk("overlap_done_out_valid", out_valid, 0);
        chk("overlap_done_in_ready", in_ready, 1);
        @(negedge clk);
        chk("overlap_second_accepted", in_ready, 0);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 30) begin @(negedge clk); n++; end
        chk("overlap_second_x", x_out, 45);
        @(negedge clk);
        out_ready = 1'b0;

        // Random sweep of the legal range plus full-width pairs, with random gaps and stalls.
        for (int i = 0; i < 1700; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (i < 1500) begin
                q = $urandom_range(0, 2849);
                r = $urandom_range(0, 22);
            end else begin
                q = $urandom_range(0, 4095);
                r = $urandom_range(0, 31);
            end
            run_pair(q, r, -1, lat, x, e, st_ok, dn_ok);
            chk($sformatf("rand q=%0d r=%0d x", q, r), x, ref_x(q, r));
            chk($sformatf("rand q=%0d r=%0d err", q, r), e, ref_err(q, r));
            chk($sformatf("rand q=%0d r=%0d latency", q, r), lat, 4);
            chk($sformatf("rand q=%0d r=%0d stable", q, r), st_ok, 1);
            chk($sformatf("rand q=%0d r=%0d handshake", q, r), dn_ok, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
